// File: rtl/neural_data_packer.sv
// Packs 16-bit acquisition samples into 32-bit words and buffers them in a circular FIFO for a host read stream.
// Optional saturating drop counter enabled by defining NEURAL_PACKER_DROP_CNT_EN.
module neural_data_packer #(
    parameter int FIFO_DEPTH = 512,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic          bus_clk,
    input  logic          reset,
    input  logic [15:0]   sample_data,
    input  logic          sample_valid,
    input  logic          sample_last,
    input  logic          open,
    input  logic          rden,
    output logic [31:0]   data,
    output logic          empty,
    output logic          eof,
    output logic          overflow,
    output logic [AW:0]   words_avail,
`ifdef NEURAL_PACKER_DROP_CNT_EN
    output logic [15:0]   drop_count,
`endif
    output logic [1:0]    run_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ENDED = 2'd2
    } run_state_e;

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_W   = (AW + 1)'(1);

    run_state_e     state_q, state_d;
    logic           open_q;
    logic [15:0]    half_q, half_d;
    logic           half_valid_q, half_valid_d;
    logic           push_q, push_d;
    logic [31:0]    push_word_q, push_word_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [31:0]    data_q, data_d;
    logic           overflow_q, overflow_d;

    logic [31:0]    mem [FIFO_DEPTH];

    logic           flush;
    logic           accept;
    logic           full;
    logic           do_write;
    logic           do_read;
    logic           do_drop;

    // Closing the stream is a flush: it overrides every push and pop in the same cycle.
    assign flush    = !open;
    assign accept   = sample_valid && open && (state_q != ENDED);
    assign full     = (count_q == DEPTH_W);
    assign do_write = push_q && !full && !flush;
    assign do_drop  = push_q && full && !flush;
    assign do_read  = rden && !empty && !flush;

    // Run state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (open && !open_q) begin
                    state_d = (accept && sample_last) ? ENDED : RUN;
                end
            end
            RUN: begin
                if (accept && sample_last) begin
                    state_d = ENDED;
                end
            end
            ENDED: state_d = ENDED;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Sample pairing; the completed word is registered, so it reaches the FIFO one cycle later.
    always_comb begin
        half_d       = half_q;
        half_valid_d = half_valid_q;
        push_d       = 1'b0;
        push_word_d  = push_word_q;
        if (flush) begin
            half_d       = 16'h0000;
            half_valid_d = 1'b0;
        end else if (accept) begin
            if (half_valid_q) begin
                push_d       = 1'b1;
                push_word_d  = {sample_data, half_q};
                half_valid_d = 1'b0;
            end else if (sample_last) begin
                push_d       = 1'b1;
                push_word_d  = {16'h0000, sample_data};
            end else begin
                half_d       = sample_data;
                half_valid_d = 1'b1;
            end
        end
    end

    // FIFO pointers, occupancy and read register
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_d     = data_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_read) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                data_d   = mem[rd_ptr_q];
            end
            if (do_drop) begin
                overflow_d = 1'b1;
            end
            case ({do_write, do_read})
                2'b10:   count_d = count_q + ONE_W;
                2'b01:   count_d = count_q - ONE_W;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            open_q       <= 1'b0;
            half_q       <= 16'h0000;
            half_valid_q <= 1'b0;
            push_q       <= 1'b0;
            push_word_q  <= 32'h0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_q       <= 32'h0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            open_q       <= open;
            half_q       <= half_d;
            half_valid_q <= half_valid_d;
            push_q       <= push_d;
            push_word_q  <= push_word_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_q       <= data_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage is deliberately not reset so it can map onto block RAM.
    always_ff @(posedge bus_clk) begin
        if (do_write) begin
            mem[wr_ptr_q] <= push_word_q;
        end
    end

`ifdef NEURAL_PACKER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            drop_cnt_d = 16'h0000;
        end else if (do_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'h0001;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            drop_cnt_q <= 16'h0000;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    // A pending half-word or an in-flight push both mean the run is not yet drained.
    assign eof         = (state_q == ENDED) && (count_q == '0) && !half_valid_q && !push_q;
    assign empty       = (count_q == '0);
    assign words_avail = count_q;
    assign data        = data_q;
    assign overflow    = overflow_q;
    assign run_state   = state_q;

endmodule
